// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parser states, rejection
// codes and the default packet sync marker.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    SKIP = 3'd4
  } state_t;

  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_SPACE = 2'd2;
  localparam logic [1:0] ERR_CHK   = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_commit_fifo.sv
// Payload FIFO with a speculative write pointer: bytes become readable only
// once committed, and an uncommitted packet can be discarded by rollback.
module uart_commit_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_4x,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [8:0]               wr_data,
  input  logic                     commit,
  input  logic                     rollback,
  input  logic                     pop,
  output logic [8:0]               rd_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] DEPTH_P = (AW + 1)'(DEPTH);

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] wr_spec_q, wr_spec_d;
  logic [AW:0] wr_commit_q, wr_commit_d;
  logic        do_pop;

  assign out_valid = (wr_commit_q != rd_ptr_q);
  assign do_pop    = pop && out_valid;
  assign rd_data   = mem_q[rd_ptr_q[AW-1:0]];
  // Occupancy counts speculative entries too, so a packet in flight reserves its space.
  assign free_cnt  = DEPTH_P - (wr_spec_q - rd_ptr_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_spec_d   = wr_spec_q;
    wr_commit_d = wr_commit_q;
    if (do_pop)   rd_ptr_d    = rd_ptr_q + PTR_ONE;
    if (wr_en)    wr_spec_d   = wr_spec_q + PTR_ONE;
    if (rollback) wr_spec_d   = wr_commit_q;
    if (commit)   wr_commit_d = wr_spec_q;
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_4x or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk_4x) begin
    if (wr_en) mem_q[wr_spec_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_framer.sv
// Packet deframer behind the UART receiver: finds sync, checks length and
// checksum, and releases payload to the consumer only for good packets.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN   = 16
) (
  input  logic       clk_4x,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code
);

  localparam int AW = $clog2(DEPTH);

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        wr_en, commit, rollback;
  logic [8:0]  rd_data;
  logic [AW:0] free_cnt;
  logic [15:0] len_w;

  assign len_w = {8'd0, in_data};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = 2'd0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: if (in_data == SYNC_BYTE) state_d = LEN;
        LEN: begin
          if (in_data == 8'd0 || len_w > 16'(MAX_LEN)) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = HUNT;
          end else if (len_w > 16'(free_cnt)) begin
            // Skip the payload plus its checksum byte.
            cnt_d   = len_w[8:0] + 9'd1;
            state_d = SKIP;
          end else begin
            cnt_d   = len_w[8:0];
            acc_d   = in_data;
            state_d = DATA;
          end
        end
        DATA: begin
          wr_en = 1'b1;
          acc_d = acc_q + in_data;
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = CHK;
        end
        CHK: begin
          if (in_data == acc_q) begin
            commit = 1'b1;
            ok_d   = 1'b1;
          end else begin
            rollback = 1'b1;
            err_d    = 1'b1;
            code_d   = ERR_CHK;
          end
          state_d = HUNT;
        end
        SKIP: begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            err_d   = 1'b1;
            code_d  = ERR_SPACE;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_4x or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      acc_q   <= '0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  uart_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_4x   (clk_4x),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  ({cnt_q == 9'd1, in_data}),
    .commit   (commit),
    .rollback (rollback),
    .pop      (out_ready),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .free_cnt (free_cnt)
  );

  assign out_data = rd_data[7:0];
  assign out_last = rd_data[8];
  assign pkt_ok   = ok_q;
  assign pkt_err  = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: one task per scenario, monitor collects
// popped bytes and result pulses on the falling edge.
module tb_uart_rx_framer;
  import uart_pkg::*;

  logic       clk_4x = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;

  int total = 0;
  int bad = 0;

  logic [8:0] rx_q[$];
  int         ok_cnt = 0;
  int         err_cnt = 0;
  logic [1:0] last_code = 2'd0;
  logic       saw_valid = 1'b0;

  uart_rx_framer #(.DEPTH(16), .SYNC_BYTE(8'hA5), .MAX_LEN(16)) dut (
    .clk_4x   (clk_4x),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pkt_ok   (pkt_ok),
    .pkt_err  (pkt_err),
    .err_code (err_code)
  );

  always #5 clk_4x = ~clk_4x;

  always @(negedge clk_4x) begin
    if (rst_n) begin
      if (out_valid) saw_valid = 1'b1;
      if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
      if (pkt_ok) ok_cnt++;
      if (pkt_err) begin
        err_cnt++;
        last_code = err_code;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk_4x);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_4x);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    ok_cnt    = 0;
    err_cnt   = 0;
    saw_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (pkt_ok !== 1'b0) begin bad++; $display("FAIL reset_pkt_ok got=%b exp=0", pkt_ok); end
    total++; if (pkt_err !== 1'b0) begin bad++; $display("FAIL reset_pkt_err got=%b exp=0", pkt_err); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good();
    logic [8:0] exp_q[$];
    clear_mon();
    out_ready = 1'b1;
    exp_q = '{9'h011, 9'h022, 9'h133};
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL good_premature_valid got=%b exp=0", out_valid); end
    send(8'h69);
    total++; if (pkt_ok !== 1'b1) begin bad++; $display("FAIL good_pkt_ok got=%b exp=1", pkt_ok); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL good_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL good_first_byte got=%h exp=11", out_data); end
    idle(6);
    total++; if (ok_cnt !== 1) begin bad++; $display("FAIL good_ok_count got=%0d exp=1", ok_cnt); end
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL good_rx_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL good_rx[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bad_chk();
    clear_mon();
    out_ready = 1'b1;
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
    total++; if (pkt_err !== 1'b1) begin bad++; $display("FAIL badchk_pkt_err got=%b exp=1", pkt_err); end
    total++; if (err_code !== ERR_CHK) begin bad++; $display("FAIL badchk_code got=%0d exp=3", err_code); end
    idle(3);
    total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL badchk_out_valid got=%b exp=0", saw_valid); end
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL badchk_err_count got=%0d exp=1", err_cnt); end
    clear_mon();
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
    total++; if (pkt_ok !== 1'b1) begin bad++; $display("FAIL badchk_next_ok got=%b exp=1", pkt_ok); end
    idle(4);
    total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL badchk_next_count got=%0d exp=1", rx_q.size()); end
    else begin
      total++; if (rx_q[0] !== 9'h15A) begin bad++; $display("FAIL badchk_next_byte got=%h exp=15a", rx_q[0]); end
    end
  endtask

  task automatic test_len_err();
    clear_mon();
    out_ready = 1'b1;
    send(8'h00); send(8'hFF); send(8'h5A);
    send(8'hA5); send(8'h00);
    total++; if (pkt_err !== 1'b1) begin bad++; $display("FAIL len0_pkt_err got=%b exp=1", pkt_err); end
    total++; if (err_code !== ERR_LEN) begin bad++; $display("FAIL len0_code got=%0d exp=1", err_code); end
    send(8'hA5); send(8'h11);
    total++; if (pkt_err !== 1'b1) begin bad++; $display("FAIL len17_pkt_err got=%b exp=1", pkt_err); end
    total++; if (err_code !== ERR_LEN) begin bad++; $display("FAIL len17_code got=%0d exp=1", err_code); end
    // Sync value in the payload position must be taken as data.
    send(8'hA5); send(8'h01); send(8'hA5); send(8'hA6);
    total++; if (pkt_ok !== 1'b1) begin bad++; $display("FAIL len_sync_data_ok got=%b exp=1", pkt_ok); end
    idle(4);
    total++; if (err_cnt !== 2) begin bad++; $display("FAIL len_err_count got=%0d exp=2", err_cnt); end
    total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL len_rx_count got=%0d exp=1", rx_q.size()); end
    else begin
      total++; if (rx_q[0] !== 9'h1A5) begin bad++; $display("FAIL len_rx_byte got=%h exp=1a5", rx_q[0]); end
    end
  endtask

  task automatic test_no_space();
    clear_mon();
    out_ready = 1'b0;
    send(8'hA5); send(8'h0E);
    for (int i = 1; i <= 14; i++) send(8'(i));
    send(8'h77);
    total++; if (pkt_ok !== 1'b1) begin bad++; $display("FAIL nospace_first_ok got=%b exp=1", pkt_ok); end
    send(8'hA5); send(8'h04);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    total++; if (pkt_err !== 1'b0) begin bad++; $display("FAIL nospace_early_err got=%b exp=0", pkt_err); end
    send(8'hA4);
    total++; if (pkt_err !== 1'b1) begin bad++; $display("FAIL nospace_pkt_err got=%b exp=1", pkt_err); end
    total++; if (err_code !== ERR_SPACE) begin bad++; $display("FAIL nospace_code got=%0d exp=2", err_code); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin bad++; $display("FAIL nospace_head got=%b/%h exp=1/01", out_valid, out_data); end
    idle(2);
    out_ready = 1'b1;
    idle(20);
    total++; if (rx_q.size() !== 14) begin bad++; $display("FAIL nospace_drain_count got=%0d exp=14", rx_q.size()); end
    for (int i = 0; i < 14 && i < rx_q.size(); i++) begin
      total++;
      if (rx_q[i] !== {i == 13, 8'(i + 1)}) begin
        bad++; $display("FAIL nospace_rx[%0d] got=%h exp=%h", i, rx_q[i], {i == 13, 8'(i + 1)});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    clear_mon();
    out_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 14; i++) exp_q.push_back({i == 13, 8'(8'h20 + i)});
    exp_q.push_back(9'h1C3);
    exp_q.push_back(9'h0F0);
    exp_q.push_back(9'h10F);
    send(8'hA5); send(8'h0E);
    for (int i = 0; i < 14; i++) send(8'(8'h20 + i));
    send(8'h29);
    send(8'hA5); send(8'h01); send(8'hC3);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_pop_during_chk got=%b exp=1", out_valid); end
    send(8'hC4);
    total++; if (pkt_ok !== 1'b1) begin bad++; $display("FAIL b2b_second_ok got=%b exp=1", pkt_ok); end
    send(8'hA5); send(8'h02); send(8'hF0); send(8'h0F); send(8'h01);
    idle(25);
    total++; if (ok_cnt !== 3) begin bad++; $display("FAIL b2b_ok_count got=%0d exp=3", ok_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL b2b_err_count got=%0d exp=0", err_cnt); end
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_rx_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_rx[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(8'hA5); send(8'h05); send(8'h01); send(8'h02);
    rst_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    total++; if (pkt_ok !== 1'b0 || pkt_err !== 1'b0) begin bad++; $display("FAIL rstmid_pulses got=%b%b exp=00", pkt_ok, pkt_err); end
    total++; if (err_code !== 2'd0) begin bad++; $display("FAIL rstmid_err_code got=%0d exp=0", err_code); end
    total++; if (dut.state_q !== HUNT) begin bad++; $display("FAIL rstmid_state got=%0d exp=%0d", dut.state_q, HUNT); end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_mon();
    send(8'hA5); send(8'h02); send(8'h07); send(8'h08); send(8'h11);
    total++; if (pkt_ok !== 1'b1) begin bad++; $display("FAIL rstmid_next_ok got=%b exp=1", pkt_ok); end
    idle(5);
    total++; if (rx_q.size() !== 2) begin bad++; $display("FAIL rstmid_rx_count got=%0d exp=2", rx_q.size()); end
    else begin
      total++; if (rx_q[0] !== 9'h007) begin bad++; $display("FAIL rstmid_rx0 got=%h exp=007", rx_q[0]); end
      total++; if (rx_q[1] !== 9'h108) begin bad++; $display("FAIL rstmid_rx1 got=%h exp=108", rx_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_chk();
    test_len_err();
    test_no_space();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
